dj_weights_ram: RTL
===================

DJ_WEIGHTS_RAM -- requirements
Module: dj_weights_ram

Interface
REQ-001 SHALL have parameter MAX_VIRTEX_NUM, default 16, meaning number of vertices (matrix rows and columns).
REQ-002 SHALL have parameter VIRTEX_DWIDTH, default 32, meaning edge weight width; all-ones encodes "no edge".
REQ-003 SHALL have parameter VIRTEX_AWIDTH, default 4, meaning row/column index width, equal to clog2(MAX_VIRTEX_NUM).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on posedge.
REQ-005 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-006 SHALL have port weights_ram_addr_i, input, VIRTEX_AWIDTH, row address from the accelerator.
REQ-007 SHALL have port weights_ram_cs_i, input, 1, read strobe from the accelerator.
REQ-008 SHALL have port weights_ram_data_o, output, unpacked [MAX_VIRTEX_NUM-1:0] of VIRTEX_DWIDTH, one full row of weights; element idx is the weight row->idx.
REQ-009 SHALL have port wr_valid_i, input, 1, host write request.
REQ-010 SHALL have port wr_ready_o, output, 1, host write accept.
REQ-011 SHALL have port wr_row_i, input, VIRTEX_AWIDTH, write source vertex.
REQ-012 SHALL have port wr_col_i, input, VIRTEX_AWIDTH, write destination vertex.
REQ-013 SHALL have port wr_data_i, input, VIRTEX_DWIDTH, write weight.
REQ-014 SHALL have port wr_err_o, output, 1, one-cycle pulse flagging a dropped write.
REQ-015 SHALL have port clear_i, input, 1, request to re-initialise the matrix to "no edge".
REQ-016 SHALL have port init_done_o, output, 1, high when the matrix is initialised and idle.

Function
REQ-017 SHALL implement FSM states INIT, IDLE, MIRROR (MIRROR exists only with DJ_WRAM_SYMMETRIC_EN).
REQ-018 INIT SHALL write one all-ones row per cycle using a row counter from 0 to MAX_VIRTEX_NUM-1, then enter IDLE; duration is exactly MAX_VIRTEX_NUM cycles.
REQ-019 init_done_o SHALL be high only in IDLE; wr_ready_o SHALL equal init_done_o.
REQ-020 Read: when cs_i is high at posedge in IDLE or MIRROR, weights_ram_data_o SHALL present row addr_i after that edge (1-cycle latency, registered).
REQ-021 weights_ram_data_o SHALL hold its last value when cs_i is low, and while in INIT regardless of cs_i.
REQ-022 A write SHALL be accepted on a posedge with wr_valid_i and wr_ready_o both high; mem[row][col] takes wr_data_i.
REQ-023 A read and an accepted write to the same row in one cycle SHALL return the pre-write row (read-before-write).
REQ-024 An accepted write with wr_row_i == wr_col_i SHALL leave memory unchanged and pulse wr_err_o for one cycle on the next cycle.
REQ-025 clear_i sampled high in any state SHALL enter INIT with the counter at 0; clear in INIT restarts the sweep; clear in MIRROR aborts the mirror write.
REQ-026 clear_i and wr_valid_i high in the same IDLE cycle SHALL give clear priority: the write is not accepted and wr_ready_o is low that cycle.

Reset
REQ-027 rst_n low SHALL asynchronously force state INIT, row counter 0, weights_ram_data_o all zeros, wr_err_o 0, init_done_o 0, wr_ready_o 0.
REQ-028 After rst_n deasserts, the INIT sweep SHALL start on the first posedge; matrix contents before sweep completion are undefined.

Configuration
REQ-029 Macro DJ_WRAM_SYMMETRIC_EN defined: an accepted non-diagonal write SHALL go to IDLE->MIRROR, write mem[col][row] with the same data on the next cycle, then return to IDLE; wr_ready_o low during MIRROR.
REQ-030 Macro DJ_WRAM_SYMMETRIC_EN undefined: writes SHALL affect only mem[row][col]; the FSM has no MIRROR state and wr_ready_o stays high throughout IDLE.

Verification
REQ-031 Reset, then count cycles -> init_done_o rises exactly 16 cycles after the rst_n release edge; read of any row returns 16 x 32'hFFFFFFFF.
REQ-032 Load edges (0,1)=0xA, (0,2)=0x1E, (0,3)=0x32, (0,4)=0xA, (4,3)=0x1E; cs_i=1, addr_i=0 -> next cycle data_o[1..4]={0xA,0x1E,0x32,0xA}, other elements all-ones.
REQ-033 Write (2,2)=0x5 -> wr_err_o pulses 1 cycle; row 2 reads all-ones.
REQ-034 Same-cycle write (3,1)=0x28 and read row 3 -> data_o[1]=all-ones; read row 3 on the next cycle -> data_o[1]=0x28.
REQ-035 clear_i pulse after loading -> init_done_o low for 16 cycles; all rows read all-ones afterwards; clear_i and wr_valid_i together -> write not accepted.
REQ-036 With DJ_WRAM_SYMMETRIC_EN: write (4,2)=0xA -> wr_ready_o low 1 cycle; rows 4 and 2 read 0xA at [2] and [4] respectively; without the macro row 2 [4] stays all-ones.

Source files
------------

// File: rtl/dj_weights_ram_if.sv
// dj_weights_ram_if: bus between the weights RAM, its host writer and the accelerator reader.
//   accelerator read: weights_ram_addr_i, weights_ram_cs_i -> weights_ram_data_o (one full row)
//   host write:       wr_valid_i, wr_row_i, wr_col_i, wr_data_i -> wr_ready_o, wr_err_o
//   control:          clear_i -> init_done_o
interface dj_weights_ram_if #(
    parameter int MAX_VIRTEX_NUM = 16,
    parameter int VIRTEX_DWIDTH  = 32,
    parameter int VIRTEX_AWIDTH  = 4
) ();
    logic [VIRTEX_AWIDTH-1:0] weights_ram_addr_i;
    logic                     weights_ram_cs_i;
    logic [VIRTEX_DWIDTH-1:0] weights_ram_data_o [MAX_VIRTEX_NUM];
    logic                     wr_valid_i;
    logic                     wr_ready_o;
    logic [VIRTEX_AWIDTH-1:0] wr_row_i;
    logic [VIRTEX_AWIDTH-1:0] wr_col_i;
    logic [VIRTEX_DWIDTH-1:0] wr_data_i;
    logic                     wr_err_o;
    logic                     clear_i;
    logic                     init_done_o;

    modport master (
        output weights_ram_addr_i, weights_ram_cs_i, wr_valid_i, wr_row_i, wr_col_i, wr_data_i, clear_i,
        input  weights_ram_data_o, wr_ready_o, wr_err_o, init_done_o
    );

    modport slave (
        input  weights_ram_addr_i, weights_ram_cs_i, wr_valid_i, wr_row_i, wr_col_i, wr_data_i, clear_i,
        output weights_ram_data_o, wr_ready_o, wr_err_o, init_done_o
    );
endinterface

// File: rtl/dj_weights_ram.sv
// dj_weights_ram: MAX_VIRTEX_NUM x MAX_VIRTEX_NUM edge-weight matrix for a Dijkstra accelerator.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : dj_weights_ram_if.slave (row read, host write, clear/init status)
// Optional feature: define DJ_WRAM_SYMMETRIC_EN to mirror every off-diagonal write into mem[col][row].
// All-ones weight encodes "no edge"; the matrix is swept to all-ones after reset and on clear_i.
module dj_weights_ram #(
    parameter int MAX_VIRTEX_NUM = 16,
    parameter int VIRTEX_DWIDTH  = 32,
    parameter int VIRTEX_AWIDTH  = 4
) (
    input logic              clk,
    input logic              rst_n,
    dj_weights_ram_if.slave  bus
);
    typedef enum logic [1:0] {
        INIT
       ,IDLE
`ifdef DJ_WRAM_SYMMETRIC_EN
       ,MIRROR
`endif
    } state_t;

    logic [VIRTEX_DWIDTH-1:0] mem [MAX_VIRTEX_NUM][MAX_VIRTEX_NUM];
    state_t                   state;
    logic [VIRTEX_AWIDTH-1:0] cnt;
    logic                     wr_acc;
    logic                     diag;

    // clear wins over a same-cycle write, so ready drops combinationally with clear_i
    assign bus.wr_ready_o = bus.init_done_o & ~bus.clear_i;
    assign wr_acc         = bus.wr_valid_i & bus.wr_ready_o;
    assign diag           = bus.wr_row_i == bus.wr_col_i;

`ifdef DJ_WRAM_SYMMETRIC_EN
    logic [VIRTEX_AWIDTH-1:0] mir_row;
    logic [VIRTEX_AWIDTH-1:0] mir_col;
    logic [VIRTEX_DWIDTH-1:0] mir_data;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= INIT;
            cnt             <= '0;
            bus.init_done_o <= 1'b0;
            bus.wr_err_o    <= 1'b0;
            for (int i = 0; i < MAX_VIRTEX_NUM; i++) bus.weights_ram_data_o[i] <= '0;
`ifdef DJ_WRAM_SYMMETRIC_EN
            mir_row  <= '0;
            mir_col  <= '0;
            mir_data <= '0;
`endif
        end else begin
            bus.wr_err_o <= wr_acc & diag;
            // mem is read with its pre-edge contents, giving read-before-write on a row collision
            if (bus.weights_ram_cs_i && state != INIT)
                for (int i = 0; i < MAX_VIRTEX_NUM; i++)
                    bus.weights_ram_data_o[i] <= mem[bus.weights_ram_addr_i][i];
            if (bus.clear_i) begin
                state           <= INIT;
                cnt             <= '0;
                bus.init_done_o <= 1'b0;
            end else begin
                case (state)
                    INIT: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == VIRTEX_AWIDTH'(MAX_VIRTEX_NUM - 1)) begin
                            state           <= IDLE;
                            bus.init_done_o <= 1'b1;
                        end
                    end
`ifdef DJ_WRAM_SYMMETRIC_EN
                    IDLE: begin
                        if (wr_acc && !diag) begin
                            state           <= MIRROR;
                            bus.init_done_o <= 1'b0;
                            mir_row         <= bus.wr_col_i;
                            mir_col         <= bus.wr_row_i;
                            mir_data        <= bus.wr_data_i;
                        end
                    end
                    MIRROR: begin
                        state           <= IDLE;
                        bus.init_done_o <= 1'b1;
                    end
`endif
                    default: state <= state;
                endcase
            end
        end
    end

    // storage has no reset: contents are defined only once the INIT sweep completes
    always_ff @(posedge clk) begin
        if (state == INIT)
            for (int i = 0; i < MAX_VIRTEX_NUM; i++) mem[cnt][i] <= '1;
        else if (wr_acc && !diag)
            mem[bus.wr_row_i][bus.wr_col_i] <= bus.wr_data_i;
`ifdef DJ_WRAM_SYMMETRIC_EN
        else if (state == MIRROR && !bus.clear_i)
            mem[mir_row][mir_col] <= mir_data;
`endif
    end
endmodule
